cis_skipper_cds_accumulator: RTL and testbench
==============================================

// Module: cis_skipper_cds_accumulator
// PURPOSE
//  Receive side of the CIS skipper readout: consumes SPROCKET sample strobes (phi1 = baseline, phi2 = signal)
//  from the CIS pattern controller plus the ADC sample stream, forms per-sample CDS (signal - baseline) and
//  sums skip_samples CDS values into one pixel result per cluster pixel. Sits between SPROCKET ADC and readout framing.
// PARAMETERS
//  ADC_W               16   unsigned ADC sample width
//  PIXEL_CLUSTER_SIZE  16   pixels per cluster; pix_idx wraps at this value (max 16)
//  ACC_W           ADC_W+11 signed accumulator/result width (1 sign + ADC_W diff + 10 bits for 1023 samples)
// PORTS
//  clk            in   1      single clock; all inputs synchronous to it
//  reset          in   1      asynchronous, active-high
//  sprocket_phi1  in   1      baseline strobe from controller; rising edge arms baseline capture
//  sprocket_phi2  in   1      signal strobe from controller; rising edge arms signal capture
//  adc_data       in   ADC_W  ADC conversion result, unsigned
//  adc_valid      in   1      adc_data valid this cycle
//  skip_samples   in   10     CDS pairs per pixel; 0 treated as 1; sampled at pixel start only
//  pix_clear      in   1      sync clear: aborts pixel, pix_idx<=0, clears sticky flags, drops held result
//  pix_data       out  ACC_W  signed CDS sum for current pixel
//  pix_nsamp      out  10     number of CDS pairs summed into pix_data
//  pix_idx        out  4      cluster pixel index of pix_data
//  pix_valid      out  1      result held; stays high until pix_ready
//  pix_ready      in   1      downstream accept; transfer when pix_valid & pix_ready
//  ovf_err        out  1      sticky: result completed while previous result still held (new result dropped)
//  seq_err        out  1      sticky: strobe out of order (phi2 edge with no baseline, or phi1 edge awaiting signal)
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, accumulator 0, counters 0, phi1_d/phi2_d 0.
//  - Edge detect: rise1 = phi1 & !phi1_d, rise2 = phi2 & !phi2_d (one register each).
//  - Capture rule: sample taken on first adc_valid cycle strictly after the rise cycle; adc_valid in the
//    rise cycle itself is ignored. Unused adc_valid cycles are discarded.
//  - FSM: IDLE, ARM_BASE, WAIT_SIG, ARM_SIG.
//    IDLE: rise1 -> latch n_tgt = max(skip_samples,1), acc<=0, cnt<=0, -> ARM_BASE. rise2 -> seq_err, stay.
//    ARM_BASE: adc_valid -> baseline<=adc_data, -> WAIT_SIG.
//    WAIT_SIG: rise2 -> ARM_SIG. rise1 -> seq_err, -> ARM_BASE (re-capture baseline, acc kept).
//    ARM_SIG: adc_valid -> acc += signed(adc_data) - signed(baseline) (ADC_W+1-bit diff, sign-extended),
//      cnt+1; if cnt+1 == n_tgt -> publish, -> IDLE; else -> WAIT_SIG (next pair starts on next rise1).
//      In WAIT_SIG (cnt>0) rise1 -> ARM_BASE without seq_err (normal next pair).
//    Edge in ARM_BASE/ARM_SIG: rise of the awaited kind re-arms (no error); other kind -> seq_err, ignored.
//  - Publish: cycle after final signal capture, pix_data=final sum, pix_nsamp=n_tgt, pix_idx=pix counter,
//    pix_valid=1. Pix counter increments on every completed pixel (published or dropped), wraps
//    PIXEL_CLUSTER_SIZE-1 -> 0.
//  - Handshake: pix_data/nsamp/idx stable while pix_valid & !pix_ready. Transfer clears pix_valid next cycle
//    unless a new publish occurs that same cycle (then new result loaded, pix_valid stays 1).
//  - Overflow: publish while pix_valid & !pix_ready -> held result kept, new dropped, ovf_err<=1.
//  - Arithmetic: no saturation; ACC_W guarantees no overflow for 1023 pairs of full-scale diffs.
//  - pix_clear has priority over all events in its cycle: FSM -> IDLE, acc/cnt 0, pix_idx 0, pix_valid 0,
//    ovf_err/seq_err 0. Edge registers still update (no spurious rise after clear).
//  - reset mid-pixel: everything returns to reset values immediately; partial sum discarded.
// TESTING
//  skip=1, rise1, adc 100, rise2, adc 250 -> pix_valid, pix_data=+150, pix_nsamp=1, pix_idx=0.
//  skip=0 -> identical to skip=1 (one pair); skip=4, pairs (100,90)x4 -> pix_data=-40, nsamp=4.
//  17 pixels skip=1, pix_ready=1 -> pix_idx 0..15 then 0; pix_clear mid-pixel -> next result idx 0, no stale sum.
//  pix_ready=0, two pixels complete -> first held unchanged, ovf_err=1, second dropped; pix_clear -> ovf_err=0.
//  rise2 in IDLE -> seq_err=1, no capture; adc_valid in rise1 cycle ignored, next valid captured as baseline.
//  skip=1023, full-scale diffs +65535 and -65535 -> pix_data=+/-67042305 exact; reset mid-pixel -> all outputs 0.

Source files
------------

// File: rtl/cis_skipper_cds_if.sv
// Pattern-controller strobes, ADC stream and pixel-result handshake between the
// SPROCKET front end and the CDS accumulator.
interface cis_skipper_cds_if #(
  parameter int ADC_W = 16,
  parameter int ACC_W = ADC_W + 11
) ();
  logic                    sprocket_phi1;
  logic                    sprocket_phi2;
  logic [ADC_W-1:0]        adc_data;
  logic                    adc_valid;
  logic [9:0]              skip_samples;
  logic                    pix_clear;
  logic signed [ACC_W-1:0] pix_data;
  logic [9:0]              pix_nsamp;
  logic [3:0]              pix_idx;
  logic                    pix_valid;
  logic                    pix_ready;
  logic                    ovf_err;
  logic                    seq_err;

  modport master (
    output sprocket_phi1, sprocket_phi2, adc_data, adc_valid, skip_samples, pix_clear, pix_ready,
    input  pix_data, pix_nsamp, pix_idx, pix_valid, ovf_err, seq_err
  );

  modport slave (
    input  sprocket_phi1, sprocket_phi2, adc_data, adc_valid, skip_samples, pix_clear, pix_ready,
    output pix_data, pix_nsamp, pix_idx, pix_valid, ovf_err, seq_err
  );
endinterface

// File: rtl/cis_skipper_cds_accumulator.sv
// Skipper CDS accumulator: pairs phi1/phi2-armed ADC samples into (signal - baseline)
// differences and sums skip_samples of them into one held pixel result.
//
//  state    | meaning
//  IDLE     | no pixel in progress; rise1 starts a pixel
//  ARM_BASE | waiting for the ADC sample that becomes the baseline
//  WAIT_SIG | baseline held, waiting for the phi2 edge
//  ARM_SIG  | waiting for the ADC sample that becomes the signal
module cis_skipper_cds_accumulator #(
  parameter int ADC_W              = 16,
  parameter int PIXEL_CLUSTER_SIZE = 16,
  parameter int ACC_W              = ADC_W + 11
) (
  input logic               clk,
  input logic               reset,
  cis_skipper_cds_if.slave  cds
);

  typedef enum logic [1:0] {IDLE, ARM_BASE, WAIT_SIG, ARM_SIG} state_t;

  state_t                  state;
  logic                    phi1_d;
  logic                    phi2_d;
  logic [ADC_W-1:0]        baseline;
  logic signed [ACC_W-1:0] acc;
  logic [9:0]              cnt;
  logic [9:0]              n_tgt;
  logic [3:0]              pix_cnt;

  logic signed [ACC_W-1:0] pix_data_q;
  logic [9:0]              pix_nsamp_q;
  logic [3:0]              pix_idx_q;
  logic                    pix_valid_q;
  logic                    ovf_err_q;
  logic                    seq_err_q;

  logic                    rise1;
  logic                    rise2;
  logic signed [ADC_W:0]   diff;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    last_pair;
  logic                    publish;
  logic [3:0]              pix_cnt_next;

  assign rise1        = cds.sprocket_phi1 & ~phi1_d;
  assign rise2        = cds.sprocket_phi2 & ~phi2_d;
  assign diff         = $signed({1'b0, cds.adc_data}) - $signed({1'b0, baseline});
  assign acc_sum      = acc + {{(ACC_W-ADC_W-1){diff[ADC_W]}}, diff};
  assign last_pair    = (cnt + 10'd1) == n_tgt;
  // A re-arming phi2 edge in ARM_SIG discards that cycle's ADC sample.
  assign publish      = (state == ARM_SIG) & ~rise2 & cds.adc_valid & last_pair;
  assign pix_cnt_next = (pix_cnt == 4'(PIXEL_CLUSTER_SIZE-1)) ? 4'd0 : pix_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phi1_d      <= 1'b0;
      phi2_d      <= 1'b0;
      baseline    <= '0;
      acc         <= '0;
      cnt         <= '0;
      n_tgt       <= '0;
      pix_cnt     <= '0;
      pix_data_q  <= '0;
      pix_nsamp_q <= '0;
      pix_idx_q   <= '0;
      pix_valid_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      phi1_d <= cds.sprocket_phi1;
      phi2_d <= cds.sprocket_phi2;
      if (cds.pix_clear) begin
        state       <= IDLE;
        acc         <= '0;
        cnt         <= '0;
        pix_cnt     <= '0;
        pix_valid_q <= 1'b0;
        ovf_err_q   <= 1'b0;
        seq_err_q   <= 1'b0;
      end else begin
        if (pix_valid_q && cds.pix_ready) pix_valid_q <= 1'b0;

        case (state)
          IDLE: begin
            if (rise1) begin
              n_tgt <= (cds.skip_samples == 10'd0) ? 10'd1 : cds.skip_samples;
              acc   <= '0;
              cnt   <= '0;
              state <= ARM_BASE;
            end else if (rise2) begin
              seq_err_q <= 1'b1;
            end
          end
          ARM_BASE: begin
            if (!rise1) begin
              if (rise2) seq_err_q <= 1'b1;
              if (cds.adc_valid) begin
                baseline <= cds.adc_data;
                state    <= WAIT_SIG;
              end
            end
          end
          WAIT_SIG: begin
            if (rise2) begin
              state <= ARM_SIG;
            end else if (rise1) begin
              // Only the first pair may not see a second phi1 before its signal.
              if (cnt == 10'd0) seq_err_q <= 1'b1;
              state <= ARM_BASE;
            end
          end
          ARM_SIG: begin
            if (!rise2) begin
              if (rise1) seq_err_q <= 1'b1;
              if (cds.adc_valid) begin
                acc   <= acc_sum;
                cnt   <= cnt + 10'd1;
                state <= last_pair ? IDLE : WAIT_SIG;
              end
            end
          end
          default: state <= IDLE;
        endcase

        if (publish) begin
          pix_cnt <= pix_cnt_next;
          if (pix_valid_q && !cds.pix_ready) begin
            ovf_err_q <= 1'b1;
          end else begin
            pix_data_q  <= acc_sum;
            pix_nsamp_q <= n_tgt;
            pix_idx_q   <= pix_cnt;
            pix_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign cds.pix_data  = pix_data_q;
  assign cds.pix_nsamp = pix_nsamp_q;
  assign cds.pix_idx   = pix_idx_q;
  assign cds.pix_valid = pix_valid_q;
  assign cds.ovf_err   = ovf_err_q;
  assign cds.seq_err   = seq_err_q;

endmodule

// File: tb/tb_cis_skipper_cds_accumulator.sv
// Bench for cis_skipper_cds_accumulator: directed literal cases plus randomized pixels
// scored against a queue of expected results computed from sample pairs.
module tb_cis_skipper_cds_accumulator;

  logic clk;
  logic reset;

  cis_skipper_cds_if #(.ADC_W(16)) bus ();

  cis_skipper_cds_accumulator #(.ADC_W(16), .PIXEL_CLUSTER_SIZE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .cds   (bus)
  );

  typedef struct {
    longint data;
    int     nsamp;
    int     idx;
  } res_t;

  res_t   exp_q[$];
  int     m_idx;
  int     n_tests;
  int     n_fail;
  bit     flags_zero;
  int     base_a[1024];
  int     sig_a[1024];

  bit     prev_held;
  longint prev_data;
  int     prev_nsamp;
  int     prev_idx;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected result of the pixel whose final signal sample is being driven now.
  task automatic model_complete(input longint esum, input int en, input bit drop);
    res_t r;
    if (!drop) begin
      r.data  = esum;
      r.nsamp = en;
      r.idx   = m_idx;
      exp_q.push_back(r);
    end
    m_idx = (m_idx + 1) % 16;
  endtask

  task automatic pair(input int b, input int s, input bit rnd, input bit junk,
                      input bit last, input longint esum, input int en, input bit drop);
    int gap;
    bus.sprocket_phi1 = 1'b1;
    bus.adc_valid     = junk;
    bus.adc_data      = 16'd9999;
    step();
    bus.adc_valid = 1'b0;
    gap = rnd ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) step();
    bus.adc_valid = 1'b1;
    bus.adc_data  = 16'(b);
    step();
    bus.sprocket_phi1 = 1'b0;
    bus.adc_valid     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.adc_data      = 16'($urandom_range(0, 65535));
    step();
    bus.sprocket_phi2 = 1'b1;
    bus.adc_valid     = junk;
    bus.adc_data      = 16'd9999;
    step();
    bus.adc_valid = 1'b0;
    gap = rnd ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) step();
    bus.adc_valid = 1'b1;
    bus.adc_data  = 16'(s);
    if (last) model_complete(esum, en, drop);
    step();
    bus.sprocket_phi2 = 1'b0;
    bus.adc_valid     = 1'b0;
    step();
  endtask

  task automatic pixel(input int skip, input bit rnd, input bit junk, input bit drop);
    int     np;
    longint s;
    np = (skip == 0) ? 1 : skip;
    s  = 0;
    for (int i = 0; i < np; i++) s += longint'(sig_a[i]) - longint'(base_a[i]);
    bus.skip_samples = 10'(skip);
    for (int i = 0; i < np; i++) begin
      pair(base_a[i], sig_a[i], rnd, junk, i == np - 1, s, np, drop);
      if (rnd && i == 0) bus.skip_samples = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic take(input string nm, input longint ed, input int en, input int ei);
    int k;
    k = 0;
    while (!bus.pix_valid && k < 200) begin
      step();
      k++;
    end
    check({nm, "_valid"}, longint'(bus.pix_valid), 1);
    check({nm, "_data"}, longint'($signed(bus.pix_data)), ed);
    check({nm, "_nsamp"}, longint'(bus.pix_nsamp), en);
    check({nm, "_idx"}, longint'(bus.pix_idx), ei);
    bus.pix_ready = 1'b1;
    step();
    bus.pix_ready = 1'b0;
  endtask

  task automatic do_clear();
    bus.pix_clear = 1'b1;
    step();
    bus.pix_clear = 1'b0;
    exp_q.delete();
    m_idx = 0;
  endtask

  task automatic set_pair(input int i, input int b, input int s);
    base_a[i] = b;
    sig_a[i]  = s;
  endtask

  // Single scoreboard process: transfers must match the queue front, held results must not move.
  always @(negedge clk) begin
    if (reset) begin
      prev_held = 1'b0;
    end else begin
      if (prev_held && bus.pix_valid) begin
        check("held_data", longint'($signed(bus.pix_data)), prev_data);
        check("held_nsamp", longint'(bus.pix_nsamp), prev_nsamp);
        check("held_idx", longint'(bus.pix_idx), prev_idx);
      end
      if (bus.pix_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", longint'(bus.pix_valid), 0);
        end else if (bus.pix_ready) begin
          check("xfer_data", longint'($signed(bus.pix_data)), exp_q[0].data);
          check("xfer_nsamp", longint'(bus.pix_nsamp), exp_q[0].nsamp);
          check("xfer_idx", longint'(bus.pix_idx), exp_q[0].idx);
          void'(exp_q.pop_front());
        end
      end
      if (flags_zero) begin
        check("seq_err_quiet", longint'(bus.seq_err), 0);
        check("ovf_err_quiet", longint'(bus.ovf_err), 0);
      end
      prev_held  = bus.pix_valid && !bus.pix_ready;
      prev_data  = longint'($signed(bus.pix_data));
      prev_nsamp = int'(bus.pix_nsamp);
      prev_idx   = int'(bus.pix_idx);
    end
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_idx = 0;
    flags_zero = 1'b0;
    prev_held = 1'b0;
    reset = 1'b1;
    bus.sprocket_phi1 = 1'b0;
    bus.sprocket_phi2 = 1'b0;
    bus.adc_data = '0;
    bus.adc_valid = 1'b0;
    bus.skip_samples = 10'd1;
    bus.pix_clear = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", longint'(bus.pix_valid), 0);
    check("rst_data", longint'($signed(bus.pix_data)), 0);
    check("rst_nsamp", longint'(bus.pix_nsamp), 0);
    check("rst_idx", longint'(bus.pix_idx), 0);
    check("rst_ovf", longint'(bus.ovf_err), 0);
    check("rst_seq", longint'(bus.seq_err), 0);
    reset = 1'b0;
    step();

    // Basic pair, skip=0 equivalence, four-pair negative sum
    set_pair(0, 100, 250);
    pixel(1, 0, 0, 0);
    take("skip1", 150, 1, 0);
    pixel(0, 0, 0, 0);
    take("skip0", 150, 1, 1);
    for (int i = 0; i < 4; i++) set_pair(i, 100, 90);
    pixel(4, 0, 0, 0);
    take("skip4", -40, 4, 2);

    // phi2 edge with nothing armed, then valid samples in rise cycles must be ignored
    bus.sprocket_phi2 = 1'b1;
    step();
    bus.sprocket_phi2 = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data = 16'd500;
    step();
    bus.adc_valid = 1'b0;
    step();
    check("seq_idle_rise2", longint'(bus.seq_err), 1);
    set_pair(0, 100, 250);
    pixel(1, 0, 1, 0);
    take("junk_rise", 150, 1, 3);
    do_clear();
    check("clear_seq", longint'(bus.seq_err), 0);
    check("clear_valid", longint'(bus.pix_valid), 0);

    // Cluster index wrap
    bus.pix_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      set_pair(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      pixel(1, 0, 0, 0);
    end
    repeat (3) step();
    bus.pix_ready = 1'b0;
    check("wrap_model_drained", longint'(exp_q.size()), 0);
    set_pair(0, 300, 200);
    pixel(1, 0, 0, 0);
    take("wrap17", -100, 1, 0);

    // Clear in the middle of a pixel
    bus.skip_samples = 10'd1;
    bus.sprocket_phi1 = 1'b1;
    step();
    bus.adc_valid = 1'b1;
    bus.adc_data = 16'd1000;
    step();
    bus.sprocket_phi1 = 1'b0;
    bus.adc_valid = 1'b0;
    step();
    bus.sprocket_phi2 = 1'b1;
    step();
    do_clear();
    bus.sprocket_phi2 = 1'b0;
    step();
    set_pair(0, 50, 60);
    pixel(1, 0, 0, 0);
    take("after_clear", 10, 1, 0);

    // Overflow: second result dropped while first is held
    set_pair(0, 10, 30);
    pixel(1, 0, 0, 0);
    set_pair(0, 5, 1);
    pixel(1, 0, 0, 1);
    step();
    check("ovf_flag", longint'(bus.ovf_err), 1);
    check("ovf_held_data", longint'($signed(bus.pix_data)), 20);
    check("ovf_held_idx", longint'(bus.pix_idx), 1);
    check("ovf_held_valid", longint'(bus.pix_valid), 1);
    do_clear();
    check("ovf_cleared", longint'(bus.ovf_err), 0);
    check("ovf_clear_valid", longint'(bus.pix_valid), 0);

    // Full-scale 1023-pair sums in both directions
    for (int i = 0; i < 1023; i++) set_pair(i, 0, 65535);
    pixel(1023, 0, 0, 0);
    take("full_pos", 67042305, 1023, 0);
    for (int i = 0; i < 1023; i++) set_pair(i, 65535, 0);
    pixel(1023, 0, 0, 0);
    take("full_neg", -67042305, 1023, 1);

    // Reset in the middle of a pixel with a result held
    set_pair(0, 1, 2);
    pixel(1, 0, 0, 0);
    bus.skip_samples = 10'd2;
    pair(5, 500, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("rstmid_valid", longint'(bus.pix_valid), 0);
    check("rstmid_data", longint'($signed(bus.pix_data)), 0);
    check("rstmid_nsamp", longint'(bus.pix_nsamp), 0);
    check("rstmid_idx", longint'(bus.pix_idx), 0);
    exp_q.delete();
    m_idx = 0;
    step();
    reset = 1'b0;
    step();
    set_pair(0, 7, 3);
    pixel(1, 0, 0, 0);
    take("after_reset", -4, 1, 0);

    // Randomized pixels, random backpressure, no errors expected
    flags_zero = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int sk;
      int np;
      sk = int'($urandom_range(0, 6));
      np = (sk == 0) ? 1 : sk;
      for (int i = 0; i < np; i++)
        set_pair(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      pixel(sk, 1, int'($urandom_range(0, 1)) == 1, 0);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
        bus.pix_ready = 1'($urandom_range(0, 1));
        step();
      end
      check("rand_drained", longint'(exp_q.size()), 0);
      exp_q.delete();
      bus.pix_ready = 1'($urandom_range(0, 1));
    end
    flags_zero = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
